tap_route: RTL and testbench
============================

TAP_ROUTE -- requirements
Module: tap_route

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 GCLK_Pad  input  1  TAP clock (TCK); all state updates SHALL occur on its rising edge.
REQ-003 TRST_Pad  input  1  asynchronous active-low reset.
REQ-004 TMS_Pad  input  1  test mode select, sampled on GCLK_Pad rising edge.
REQ-005 state_obs0_Pad  output  1  state code bit 0 (LSB).
REQ-006 state_obs1_Pad  output  1  state code bit 1.
REQ-007 state_obs2_Pad  output  1  state code bit 2.
REQ-008 state_obs3_Pad  output  1  state code bit 3 (MSB).
REQ-009 The block SHALL have no parameters; the only build option SHALL be the macro in Configuration.

Function
REQ-010 The block SHALL implement the 16-state IEEE 1149.1 TAP controller FSM.
REQ-011 Transitions, as state: TMS=0 / TMS=1:
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- CapDR: ShDR / Ex1DR
- ShDR: ShDR / Ex1DR
- Ex1DR: PauDR / UpdDR
- PauDR: PauDR / Ex2DR
- Ex2DR: ShDR / UpdDR
- UpdDR: RTI / SelDR
- SelIR: CapIR / TLR
- CapIR: ShIR / Ex1IR
- ShIR: ShIR / Ex1IR
- Ex1IR: PauIR / UpdIR
- PauIR: PauIR / Ex2IR
- Ex2IR: ShIR / UpdIR
- UpdIR: RTI / SelDR
REQ-012 Latency SHALL be exactly one clock: the sampled TMS determines the state held after that rising edge.
REQ-013 The outputs SHALL be driven directly from the 4-bit state register, with no combinational path from TMS_Pad.
REQ-014 From any state, five consecutive TMS=1 clocks SHALL reach TLR.
REQ-015 All 16 codes SHALL be legal, so no illegal-state recovery is required.

Reset
REQ-016 While TRST_Pad=0 the state SHALL be TLR regardless of the clock, and outputs SHALL show the TLR code.
REQ-017 Asserting TRST_Pad mid-sequence SHALL force TLR immediately, without waiting for a clock edge.
REQ-018 On a clock edge coincident with TRST_Pad=0, reset SHALL win.
REQ-019 After release, the first rising edge SHALL apply the normal TMS transition from TLR.

Configuration
REQ-020 With TAP_IEEE_ENCODING_EN defined, outputs SHALL use these hex codes:
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
REQ-021 Without TAP_IEEE_ENCODING_EN, outputs SHALL use sequential codes 0..15 in the REQ-011 listing order (TLR=0 ... UpdIR=15).
REQ-022 The FSM behaviour SHALL be identical under both encodings.

Verification (TAP_IEEE_ENCODING_EN defined)
REQ-023 TRST_Pad=0 for 20 clocks with any TMS -> obs=F throughout; then TRST_Pad=0 asserted between clock edges while in RTI -> obs=F immediately.
REQ-024 After reset release, TMS 0,1,0,0 -> obs C,7,6,2.
REQ-025 From ShDR, TMS 1,0,1,1,0 -> obs 1,3,0,5,C.
REQ-026 From RTI, TMS 1,1,0,0,1,1,0 -> obs 7,4,E,A,9,D,C.
REQ-027 From PauIR, TMS 1,1,1,1,1 -> obs B stays until the first edge, then reaches F within 5 clocks and stays F on further TMS=1.
REQ-028 Build without the macro and rerun REQ-024 -> obs 1,2,3,4.

Source files
------------

// File: rtl/tap_route.sv
// IEEE 1149.1 TAP controller state machine with the state code driven straight from the register.
// Build option: define TAP_IEEE_ENCODING_EN for the IEEE-style hex state codes; default is sequential 0..15.
module tap_route (
  input  logic GCLK_Pad,
  input  logic TRST_Pad,
  input  logic TMS_Pad,
  output logic state_obs0_Pad,
  output logic state_obs1_Pad,
  output logic state_obs2_Pad,
  output logic state_obs3_Pad
);

  localparam int unsigned STATE_W = 4;

`ifdef TAP_IEEE_ENCODING_EN
  typedef enum logic [STATE_W-1:0] {
    S_TLR   = 4'hF,
    S_RTI   = 4'hC,
    S_SELDR = 4'h7,
    S_CAPDR = 4'h6,
    S_SHDR  = 4'h2,
    S_EX1DR = 4'h1,
    S_PAUDR = 4'h3,
    S_EX2DR = 4'h0,
    S_UPDDR = 4'h5,
    S_SELIR = 4'h4,
    S_CAPIR = 4'hE,
    S_SHIR  = 4'hA,
    S_EX1IR = 4'h9,
    S_PAUIR = 4'hB,
    S_EX2IR = 4'h8,
    S_UPDIR = 4'hD
  } tap_state_e;
`else
  typedef enum logic [STATE_W-1:0] {
    S_TLR   = 4'd0,
    S_RTI   = 4'd1,
    S_SELDR = 4'd2,
    S_CAPDR = 4'd3,
    S_SHDR  = 4'd4,
    S_EX1DR = 4'd5,
    S_PAUDR = 4'd6,
    S_EX2DR = 4'd7,
    S_UPDDR = 4'd8,
    S_SELIR = 4'd9,
    S_CAPIR = 4'd10,
    S_SHIR  = 4'd11,
    S_EX1IR = 4'd12,
    S_PAUIR = 4'd13,
    S_EX2IR = 4'd14,
    S_UPDIR = 4'd15
  } tap_state_e;
`endif

  tap_state_e r_state;

  // Every code is a real state, so the default arm only exists for completeness.
  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      r_state <= S_TLR;
    end else begin
      case (r_state)
        S_TLR:   r_state <= TMS_Pad ? S_TLR   : S_RTI;
        S_RTI:   r_state <= TMS_Pad ? S_SELDR : S_RTI;
        S_SELDR: r_state <= TMS_Pad ? S_SELIR : S_CAPDR;
        S_CAPDR: r_state <= TMS_Pad ? S_EX1DR : S_SHDR;
        S_SHDR:  r_state <= TMS_Pad ? S_EX1DR : S_SHDR;
        S_EX1DR: r_state <= TMS_Pad ? S_UPDDR : S_PAUDR;
        S_PAUDR: r_state <= TMS_Pad ? S_EX2DR : S_PAUDR;
        S_EX2DR: r_state <= TMS_Pad ? S_UPDDR : S_SHDR;
        S_UPDDR: r_state <= TMS_Pad ? S_SELDR : S_RTI;
        S_SELIR: r_state <= TMS_Pad ? S_TLR   : S_CAPIR;
        S_CAPIR: r_state <= TMS_Pad ? S_EX1IR : S_SHIR;
        S_SHIR:  r_state <= TMS_Pad ? S_EX1IR : S_SHIR;
        S_EX1IR: r_state <= TMS_Pad ? S_UPDIR : S_PAUIR;
        S_PAUIR: r_state <= TMS_Pad ? S_EX2IR : S_PAUIR;
        S_EX2IR: r_state <= TMS_Pad ? S_UPDIR : S_SHIR;
        S_UPDIR: r_state <= TMS_Pad ? S_SELDR : S_RTI;
        default: r_state <= S_TLR;
      endcase
    end
  end

  assign state_obs0_Pad = r_state[0];
  assign state_obs1_Pad = r_state[1];
  assign state_obs2_Pad = r_state[2];
  assign state_obs3_Pad = r_state[3];

endmodule

// File: tb/tb_tap_route.sv
// Directed bench for tap_route; expected codes follow TAP_IEEE_ENCODING_EN when it is defined.
module tb_tap_route;

  logic clk    = 1'b0;
  logic trst_n = 1'b1;
  logic tms    = 1'b0;
  logic obs0, obs1, obs2, obs3;
  logic [3:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

  tap_route dut (
    .GCLK_Pad      (clk),
    .TRST_Pad      (trst_n),
    .TMS_Pad       (tms),
    .state_obs0_Pad(obs0),
    .state_obs1_Pad(obs1),
    .state_obs2_Pad(obs2),
    .state_obs3_Pad(obs3)
  );

  assign obs = {obs3, obs2, obs1, obs0};

  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input int s);
`ifdef TAP_IEEE_ENCODING_EN
    case (s)
      TLR:   return 4'hF;
      RTI:   return 4'hC;
      SELDR: return 4'h7;
      CAPDR: return 4'h6;
      SHDR:  return 4'h2;
      EX1DR: return 4'h1;
      PAUDR: return 4'h3;
      EX2DR: return 4'h0;
      UPDDR: return 4'h5;
      SELIR: return 4'h4;
      CAPIR: return 4'hE;
      SHIR:  return 4'hA;
      EX1IR: return 4'h9;
      PAUIR: return 4'hB;
      EX2IR: return 4'h8;
      default: return 4'hD;
    endcase
`else
    return 4'(s);
`endif
  endfunction

  // Drive TMS after a falling edge, clock once, and return on the next falling edge.
  task automatic tick(input logic t);
    tms = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_to_tlr();
    trst_n = 1'b0;
    #1;
    @(negedge clk);
    trst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 trst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== enc(TLR)) begin
      n_fail++;
      $display("FAIL reset_async_initial: obs=%h expected=%h", obs, enc(TLR));
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (obs !== enc(TLR)) begin
        n_fail++;
        $display("FAIL reset_held clk %0d: obs=%h expected=%h", i, obs, enc(TLR));
      end
    end
    trst_n = 1'b1;
    tick(1'b0);
    n_checks++;
    if (obs !== enc(RTI)) begin
      n_fail++;
      $display("FAIL reset_release_to_rti: obs=%h expected=%h", obs, enc(RTI));
    end
    #2 trst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== enc(TLR)) begin
      n_fail++;
      $display("FAIL reset_mid_cycle: obs=%h expected=%h", obs, enc(TLR));
    end
    @(negedge clk);
    tick(1'b0);
    n_checks++;
    if (obs !== enc(TLR)) begin
      n_fail++;
      $display("FAIL reset_wins_edge: obs=%h expected=%h", obs, enc(TLR));
    end
    trst_n = 1'b1;
    tick(1'b1);
    n_checks++;
    if (obs !== enc(TLR)) begin
      n_fail++;
      $display("FAIL release_tms1_stays_tlr: obs=%h expected=%h", obs, enc(TLR));
    end
  endtask

  task automatic test_dr_path();
    logic t[9];
    int   e[9];
    t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    e = '{RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR, RTI};
    reset_to_tlr();
    for (int i = 0; i < 9; i++) begin
      tick(t[i]);
      n_checks++;
      if (obs !== enc(e[i])) begin
        n_fail++;
        $display("FAIL dr_path step %0d: obs=%h expected=%h", i, obs, enc(e[i]));
      end
    end
  endtask

  task automatic test_ir_path();
    logic t[7];
    int   e[7];
    t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    e = '{SELDR, SELIR, CAPIR, SHIR, EX1IR, UPDIR, RTI};
    for (int i = 0; i < 7; i++) begin
      tick(t[i]);
      n_checks++;
      if (obs !== enc(e[i])) begin
        n_fail++;
        $display("FAIL ir_path step %0d: obs=%h expected=%h", i, obs, enc(e[i]));
      end
    end
  endtask

  task automatic test_loops();
    logic t[30];
    int   e[30];
    t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
          1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
          1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e = '{RTI, SELDR, CAPDR, SHDR, SHDR, EX1DR, PAUDR, PAUDR, EX2DR, SHDR,
          EX1DR, UPDDR, SELDR, SELIR, CAPIR, EX1IR, PAUIR, EX2IR, SHIR, EX1IR,
          PAUIR, EX2IR, UPDIR, RTI, SELDR, CAPDR, EX1DR, UPDDR, SELDR, CAPDR};
    for (int i = 0; i < 30; i++) begin
      tick(t[i]);
      n_checks++;
      if (obs !== enc(e[i])) begin
        n_fail++;
        $display("FAIL loops step %0d: obs=%h expected=%h", i, obs, enc(e[i]));
      end
    end
  endtask

  task automatic test_five_ones();
    logic t[6];
    int   e[6];
    int   ones[5];
    t    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    e    = '{SHDR, SHDR, SHDR, EX1DR, UPDDR, RTI};
    ones = '{EX1DR, UPDDR, SELDR, SELIR, TLR};
    // From ShDR (reached at the end of test_loops via CapDR, then TMS=0).
    tick(1'b0);
    n_checks++;
    if (obs !== enc(SHDR)) begin
      n_fail++;
      $display("FAIL five_ones_enter_shdr: obs=%h expected=%h", obs, enc(SHDR));
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      n_checks++;
      if (obs !== enc(ones[i])) begin
        n_fail++;
        $display("FAIL five_ones_from_shdr step %0d: obs=%h expected=%h", i, obs, enc(ones[i]));
      end
    end
    // TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR -> Ex1IR -> PauIR
    t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    e = '{RTI, SELDR, SELIR, CAPIR, SHIR, EX1IR};
    for (int i = 0; i < 6; i++) begin
      tick(t[i]);
      n_checks++;
      if (obs !== enc(e[i])) begin
        n_fail++;
        $display("FAIL reach_pauir step %0d: obs=%h expected=%h", i, obs, enc(e[i]));
      end
    end
    tick(1'b0);
    tms = 1'b1;
    #1;
    n_checks++;
    if (obs !== enc(PAUIR)) begin
      n_fail++;
      $display("FAIL pauir_holds_before_edge: obs=%h expected=%h", obs, enc(PAUIR));
    end
    ones = '{EX2IR, UPDIR, SELDR, SELIR, TLR};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      n_checks++;
      if (obs !== enc(ones[i])) begin
        n_fail++;
        $display("FAIL five_ones_from_pauir step %0d: obs=%h expected=%h", i, obs, enc(ones[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_checks++;
      if (obs !== enc(TLR)) begin
        n_fail++;
        $display("FAIL tlr_sticky step %0d: obs=%h expected=%h", i, obs, enc(TLR));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dr_path();
    test_ir_path();
    test_loops();
    test_five_ones();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
